sa_skew_feeder: RTL and testbench

- Feeds the systolic PE array from the west edge (A operands, one lane per row) and the north edge (B operands, one lane per column).
- Accepts one A row-vector and one B column-vector per beat, skews lane r by r cycles, and zero-pads bubbles.
- After the last beat, flushes the array, then asserts the drain control (i_ctrl_sa_send_data of the PEs) long enough to shift all accumulators out.
- Sits between the operand buffers and the PE array; one job per i_start.

---
 rtl/sa_pkg.sv | 27 ++
 rtl/sa_skew_feeder_if.sv | 25 ++
 rtl/sa_skew_line.sv | 29 ++
 rtl/sa_skew_feeder.sv | 171 +++++++++++++++++
 tb/tb_sa_skew_feeder.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sa_pkg.sv
// Shared types and sizing helpers for the systolic-array skew feeder.
package sa_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    FLUSH,
    DRAIN
  } sa_feed_state_e;

  localparam int unsigned SA_ROWS_DEFAULT  = 4;
  localparam int unsigned SA_COLS_DEFAULT  = 4;
  localparam int unsigned IN_WIDTH_DEFAULT = 8;
  localparam int unsigned K_MAX_DEFAULT    = 256;

  // Width of a counter able to hold the value max_val.
  function automatic int unsigned sa_cnt_w(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

  // Zero beats needed after the last real beat: longest skew, propagation to
  // the far corner PE, and that PE's accumulate register.
  function automatic int unsigned sa_flush_len(input int unsigned rows, input int unsigned cols);
    return rows + cols - 1;
  endfunction

endpackage

// File: rtl/sa_skew_feeder_if.sv
// Operand handshake bundle between the A/B operand buffers and the skew feeder.
interface sa_skew_feeder_if #(
  parameter int unsigned SA_ROWS  = 4,
  parameter int unsigned SA_COLS  = 4,
  parameter int unsigned IN_WIDTH = 8
);

  logic                        i_a_valid;
  logic [SA_ROWS*IN_WIDTH-1:0] i_a_data;
  logic                        o_a_ready;
  logic                        i_b_valid;
  logic [SA_COLS*IN_WIDTH-1:0] i_b_data;
  logic                        o_b_ready;

  modport master (
    output i_a_valid, i_a_data, i_b_valid, i_b_data,
    input  o_a_ready, o_b_ready
  );

  modport slave (
    input  i_a_valid, i_a_data, i_b_valid, i_b_data,
    output o_a_ready, o_b_ready
  );

endinterface

// File: rtl/sa_skew_line.sv
// Fixed-depth register delay line for one skewed operand lane.
module sa_skew_line #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= i_data;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign o_data = stage_q[DEPTH-1];

endmodule

// File: rtl/sa_skew_feeder.sv
// West/north edge feeder for the systolic PE array: skew, flush, then drain.
// Optional perf counters are enabled with `define SA_SKEW_FEEDER_PERF_EN.
module sa_skew_feeder
  import sa_pkg::*;
#(
  parameter int unsigned SA_ROWS  = SA_ROWS_DEFAULT,
  parameter int unsigned SA_COLS  = SA_COLS_DEFAULT,
  parameter int unsigned IN_WIDTH = IN_WIDTH_DEFAULT,
  parameter int unsigned K_MAX    = K_MAX_DEFAULT,
  parameter int unsigned CNT_W    = sa_cnt_w(K_MAX)
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_start,
  input  logic [CNT_W-1:0]            i_k_len,
  sa_skew_feeder_if.slave             bus,
  output logic [SA_ROWS*IN_WIDTH-1:0] o_sa_a,
  output logic [SA_COLS*IN_WIDTH-1:0] o_sa_b,
  output logic                        o_ctrl_sa_send_data,
  output logic                        o_busy,
  output logic                        o_done
`ifdef SA_SKEW_FEEDER_PERF_EN
  ,
  output logic [31:0]                 o_perf_stall_cnt,
  output logic [31:0]                 o_perf_cycle_cnt
`endif
);

  localparam int unsigned FLUSH_LEN = sa_flush_len(SA_ROWS, SA_COLS);
  localparam int unsigned STEP_W    = sa_cnt_w((FLUSH_LEN > SA_ROWS) ? FLUSH_LEN : SA_ROWS);
  localparam logic [STEP_W-1:0] FLUSH_LAST = STEP_W'(FLUSH_LEN - 1);
  localparam logic [STEP_W-1:0] DRAIN_LAST = STEP_W'(SA_ROWS - 1);

  sa_feed_state_e    state_q;
  logic [CNT_W-1:0]  k_len_q;
  logic [CNT_W-1:0]  beat_cnt_q;
  logic [STEP_W-1:0] step_cnt_q;
  logic              busy_q;
  logic              drain_q;
  logic              done_q;

  logic in_feed;
  logic fire;
  logic [SA_ROWS*IN_WIDTH-1:0] a_in;
  logic [SA_COLS*IN_WIDTH-1:0] b_in;

  assign in_feed       = (state_q == FEED);
  assign fire          = in_feed & bus.i_a_valid & bus.i_b_valid;
  assign bus.o_a_ready = in_feed & bus.i_b_valid;
  assign bus.o_b_ready = in_feed & bus.i_a_valid;

  // Non-fire cycles inject zero bubbles; a zero product leaves accumulators untouched.
  assign a_in = fire ? bus.i_a_data : '0;
  assign b_in = fire ? bus.i_b_data : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      k_len_q    <= '0;
      beat_cnt_q <= '0;
      step_cnt_q <= '0;
      busy_q     <= 1'b0;
      drain_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_start) begin
            if (i_k_len != '0) begin
              k_len_q    <= i_k_len;
              beat_cnt_q <= '0;
              busy_q     <= 1'b1;
              state_q    <= FEED;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        FEED: begin
          if (fire) begin
            if (beat_cnt_q == k_len_q - CNT_W'(1)) begin
              beat_cnt_q <= '0;
              step_cnt_q <= '0;
              state_q    <= FLUSH;
            end else begin
              beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            end
          end
        end
        FLUSH: begin
          if (step_cnt_q == FLUSH_LAST) begin
            step_cnt_q <= '0;
            drain_q    <= 1'b1;
            state_q    <= DRAIN;
          end else begin
            step_cnt_q <= step_cnt_q + STEP_W'(1);
          end
        end
        DRAIN: begin
          if (step_cnt_q == DRAIN_LAST) begin
            step_cnt_q <= '0;
            drain_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= IDLE;
          end else begin
            step_cnt_q <= step_cnt_q + STEP_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ctrl_sa_send_data = drain_q;
  assign o_busy              = busy_q;
  assign o_done              = done_q;

  for (genvar r = 0; r < SA_ROWS; r++) begin : g_a_lane
    sa_skew_line #(
      .WIDTH (IN_WIDTH),
      .DEPTH (r + 1)
    ) u_line (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_data  (a_in[r*IN_WIDTH +: IN_WIDTH]),
      .o_data  (o_sa_a[r*IN_WIDTH +: IN_WIDTH])
    );
  end

  for (genvar c = 0; c < SA_COLS; c++) begin : g_b_lane
    sa_skew_line #(
      .WIDTH (IN_WIDTH),
      .DEPTH (c + 1)
    ) u_line (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_data  (b_in[c*IN_WIDTH +: IN_WIDTH]),
      .o_data  (o_sa_b[c*IN_WIDTH +: IN_WIDTH])
    );
  end

`ifdef SA_SKEW_FEEDER_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] cycle_cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt_q <= '0;
      cycle_cnt_q <= '0;
    end else if (state_q == IDLE) begin
      if (i_start) begin
        stall_cnt_q <= '0;
        cycle_cnt_q <= '0;
      end
    end else begin
      if (cycle_cnt_q != '1) begin
        cycle_cnt_q <= cycle_cnt_q + 32'd1;
      end
      if (in_feed && !fire && stall_cnt_q != '1) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign o_perf_stall_cnt = stall_cnt_q;
  assign o_perf_cycle_cnt = cycle_cnt_q;
`endif

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Self-checking bench for sa_skew_feeder with a cycle-timed reference and a behavioural PE array.
module tb_sa_skew_feeder;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int W    = 8;
  localparam int CW   = 9;
  localparam int AW   = ROWS * W;
  localparam int BW   = COLS * W;
  localparam int FL   = ROWS + COLS - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start;
  logic [CW-1:0] k_len;
  logic [AW-1:0] sa_a;
  logic [BW-1:0] sa_b;
  logic          send, busy, done;
`ifdef SA_SKEW_FEEDER_PERF_EN
  logic [31:0]   perf_stall, perf_cycle;
`endif

  always #5 clk = ~clk;

  sa_skew_feeder_if #(.SA_ROWS(ROWS), .SA_COLS(COLS), .IN_WIDTH(W)) bus ();

  sa_skew_feeder #(
    .SA_ROWS  (ROWS),
    .SA_COLS  (COLS),
    .IN_WIDTH (W),
    .K_MAX    (256)
  ) dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .i_start             (start),
    .i_k_len             (k_len),
    .bus                 (bus.slave),
    .o_sa_a              (sa_a),
    .o_sa_b              (sa_b),
    .o_ctrl_sa_send_data (send),
    .o_busy              (busy),
    .o_done              (done)
`ifdef SA_SKEW_FEEDER_PERF_EN
    ,
    .o_perf_stall_cnt    (perf_stall),
    .o_perf_cycle_cnt    (perf_cycle)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: job timeline expressed as cycle numbers plus a history of fired beats.
  int cyc;
  bit m_job;
  int m_left, m_busy_from, m_end, m_done;
  int done_seen_cyc, done_count;
  logic [AW-1:0] hist_a [int];
  logic [BW-1:0] hist_b [int];

  // Behavioural output-stationary PE array fed by the DUT.
  int acc  [ROWS][COLS];
  int areg [ROWS][COLS];
  int breg [ROWS][COLS];
  int cap  [ROWS][COLS];
  int drain_k;

  function automatic int a_in(input int r, input int c);
    if (c == 0) return int'(sa_a[r*W +: W]);
    return areg[r][c-1];
  endfunction

  function automatic int b_in(input int r, input int c);
    if (r == 0) return int'(sa_b[c*W +: W]);
    return breg[r-1][c];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          acc[r][c]  <= 0;
          areg[r][c] <= 0;
          breg[r][c] <= 0;
        end
      drain_k <= 0;
    end else if (send) begin
      for (int c = 0; c < COLS; c++) begin
        if (drain_k < ROWS) cap[drain_k][c] <= acc[ROWS-1][c];
        for (int r = 0; r < ROWS; r++) begin
          if (r == 0) acc[0][c] <= 0;
          else        acc[r][c] <= acc[r-1][c];
        end
      end
      drain_k <= drain_k + 1;
    end else begin
      drain_k <= 0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          acc[r][c]  <= acc[r][c] + a_in(r, c) * b_in(r, c);
          areg[r][c] <= a_in(r, c);
          breg[r][c] <= b_in(r, c);
        end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [AW-1:0] ea, ha;
    logic [BW-1:0] eb, hb;
    ea = '0;
    eb = '0;
    for (int r = 0; r < ROWS; r++)
      if (hist_a.exists(cyc - 1 - r)) begin
        ha = hist_a[cyc - 1 - r];
        ea[r*W +: W] = ha[r*W +: W];
      end
    for (int c = 0; c < COLS; c++)
      if (hist_b.exists(cyc - 1 - c)) begin
        hb = hist_b[cyc - 1 - c];
        eb[c*W +: W] = hb[c*W +: W];
      end
    chk("sa_a", sa_a, ea);
    chk("sa_b", sa_b, eb);
    chk("busy", busy, m_job && cyc >= m_busy_from && cyc <= m_end);
    chk("send_data", send, m_job && cyc > m_end - ROWS && cyc <= m_end);
    chk("done", done, cyc == m_done);
    if (done === 1'b1) begin
      done_seen_cyc = cyc;
      done_count++;
    end
  endtask

  // Called at a falling edge: drive this cycle's inputs, check readies, advance one cycle.
  task automatic step(input logic st, input logic [CW-1:0] kl, input logic av, input logic bv,
                      input logic [AW-1:0] ad, input logic [BW-1:0] bd);
    bit feed, idle;
    start = st;
    k_len = kl;
    bus.i_a_valid = av;
    bus.i_b_valid = bv;
    bus.i_a_data  = ad;
    bus.i_b_data  = bd;
    #1;
    feed = m_job && m_left > 0 && cyc >= m_busy_from;
    idle = !m_job || cyc > m_end;
    chk("a_ready", bus.o_a_ready, feed && bv);
    chk("b_ready", bus.o_b_ready, feed && av);
    if (feed && av && bv) begin
      hist_a[cyc] = ad;
      hist_b[cyc] = bd;
      m_left--;
      if (m_left == 0) begin
        m_end  = cyc + FL + ROWS;
        m_done = m_end + 1;
      end
    end
    if (st && idle) begin
      if (kl != '0) begin
        m_job       = 1;
        m_busy_from = cyc + 1;
        m_left      = int'(kl);
        m_end       = 1 << 30;
      end else begin
        m_done = cyc + 1;
      end
    end
    @(negedge clk);
    cyc++;
    check_outputs();
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic reset_pulse();
    bus.i_b_valid = 1'b1;
    bus.i_a_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_sa_a", sa_a, '0);
    chk("rst_sa_b", sa_b, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_send", send, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_a_ready", bus.o_a_ready, 1'b0);
    m_job  = 0;
    m_left = 0;
    m_done = -1;
    m_end  = -1;
    hist_a.delete();
    hist_b.delete();
    @(negedge clk);
    cyc++;
    check_outputs();
    rst_n = 1'b1;
  endtask

  logic [AW-1:0] a1, av_vec;
  logic [BW-1:0] b1, bv_vec;
  int t0, t1, kr, sum;
  int a_m [ROWS][ROWS];
  int b_m [ROWS][COLS];

  initial begin
    start = 1'b0;
    k_len = '0;
    bus.i_a_valid = 1'b0;
    bus.i_b_valid = 1'b0;
    bus.i_a_data  = '0;
    bus.i_b_data  = '0;
    cyc = 0;
    m_job = 0; m_left = 0; m_busy_from = 0; m_end = -1; m_done = -1;
    done_seen_cyc = -1;
    done_count = 0;

    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // Plain job, k_len=3, valids held high.
    a1 = {8'h13, 8'h12, 8'h11, 8'h10};
    b1 = {8'h24, 8'h23, 8'h22, 8'h21};
    t0 = cyc;
    step(1'b1, 9'd3, 1'b1, 1'b1, a1, b1);
    repeat (18) step(1'b0, '0, 1'b1, 1'b1, a1, b1);
    chk("t1_done_cycle", done_seen_cyc - t0, 15);

    // k_len=4 with B stalled for two beats.
    t0 = cyc;
    step(1'b1, 9'd4, 1'b1, 1'b1, '0, '0);
    for (int i = 1; i <= 6; i++)
      step(1'b0, '0, 1'b1, !(i == 3 || i == 4), AW'($urandom), BW'($urandom));
    idle_steps(14);
    chk("t2_done_cycle", done_seen_cyc - t0, 18);

    // Zero-length job.
    done_count = 0;
    t0 = cyc;
    step(1'b1, 9'd0, 1'b0, 1'b0, '0, '0);
    idle_steps(3);
    chk("t3_done_cycle", done_seen_cyc - t0, 1);
    chk("t3_done_count", done_count, 1);

    // Start pulses during FEED and DRAIN are ignored.
    done_count = 0;
    t0 = cyc;
    step(1'b1, 9'd2, 1'b0, 1'b0, '0, '0);
    for (int i = 1; i <= 20; i++)
      step((i == 2) || (i == 11), (i == 2) ? 9'd5 : 9'd7, i <= 2, i <= 2,
           AW'($urandom), BW'($urandom));
    chk("t4_done_count", done_count, 1);
    chk("t4_done_cycle", done_seen_cyc - t0, 14);

    // Reset mid-FLUSH, then a fresh job.
    done_count = 0;
    step(1'b1, 9'd3, 1'b1, 1'b1, a1, b1);
    for (int i = 1; i <= 5; i++) step(1'b0, '0, i <= 3, i <= 3, a1, b1);
    reset_pulse();
    chk("t5_no_done_after_reset", done_count, 0);
    t1 = cyc;
    step(1'b1, 9'd2, 1'b1, 1'b1, a1, b1);
    repeat (18) step(1'b0, '0, 1'b1, 1'b1, b1, a1);
    chk("t5_done_count", done_count, 1);
    chk("t5_done_cycle", done_seen_cyc - t1, 14);

    // End-to-end through the PE array: identity B reproduces A.
    for (int r = 0; r < ROWS; r++)
      for (int j = 0; j < ROWS; j++) a_m[r][j] = r * ROWS + j + 1;
    for (int j = 0; j < ROWS; j++)
      for (int c = 0; c < COLS; c++) b_m[j][c] = (j == c) ? 1 : 0;
    step(1'b1, 9'd4, 1'b0, 1'b0, '0, '0);
    for (int k = 0; k < ROWS; k++) begin
      for (int r = 0; r < ROWS; r++) av_vec[r*W +: W] = W'(a_m[r][k]);
      for (int c = 0; c < COLS; c++) bv_vec[c*W +: W] = W'(b_m[k][c]);
      step(1'b0, '0, 1'b1, 1'b1, av_vec, bv_vec);
    end
    idle_steps(14);
    for (int k = 0; k < ROWS; k++)
      for (int c = 0; c < COLS; c++) begin
        sum = 0;
        for (int j = 0; j < ROWS; j++) sum += a_m[ROWS-1-k][j] * b_m[j][c];
        chk($sformatf("t6_c_r%0d_c%0d", ROWS - 1 - k, c), cap[k][c], sum);
      end
    sum = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) sum += (acc[r][c] < 0) ? -acc[r][c] : acc[r][c];
    chk("t6_acc_cleared", sum, 0);

    // Randomized jobs with random stalls, data and stray starts.
    repeat (12) begin
      kr = $urandom_range(0, 6);
      step(1'b1, CW'(kr), 1'b0, 1'b0, '0, '0);
      for (int i = 0; i < 40; i++)
        step($urandom_range(0, 19) == 0, CW'($urandom_range(0, 3)),
             $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
             AW'($urandom), BW'($urandom));
    end
    idle_steps(30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
